demux_1_2_buffered: RTL and testbench
=====================================

# demux_1_2_buffered

Buffered 1:2 demultiplexer with valid/ready handshaking that steers a single stream of data words to one of two destination ports. Each destination has its own 2-entry FIFO, so a stalled destination never blocks traffic already queued for the other. It sits in the core datapath wherever one producer feeds two consumers, for example store data going to data memory or to the MMIO peripheral bus. It is the splitting counterpart of the general-purpose 2:1 multiplexer.

## Interface
Parameters:
- INPUT_DATA_WIDTH, 32: width of every data bus.

Ports:
- DEMUX_CLOCK_50  input  1  clock; all state changes on its rising edge.
- DEMUX_RESET_InHigh  input  1  reset, synchronous, active-high.
- DEMUX_Input_Data  input  INPUT_DATA_WIDTH  incoming word.
- DEMUX_Input_Valid  input  1  incoming word is valid.
- DEMUX_Sel  input  1  destination of the incoming word: 0 selects port 0, 1 selects port 1. Sampled only with DEMUX_Input_Valid.
- DEMUX_Input_Ready  output  1  block can accept the incoming word this cycle.
- DEMUX_Output_0_Data  output  INPUT_DATA_WIDTH  head word of FIFO 0.
- DEMUX_Output_0_Valid  output  1  FIFO 0 is not empty.
- DEMUX_Output_0_Ready  input  1  consumer 0 accepts the head word.
- DEMUX_Output_1_Data, DEMUX_Output_1_Valid, DEMUX_Output_1_Ready: same as port 0, for FIFO 1.

## Operation
- Per-port state: two storage words, 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
- Ready: DEMUX_Input_Ready = (count of the FIFO selected by DEMUX_Sel) < 2. This is combinational from DEMUX_Sel and registered counts.
  - No credit is given for a same-cycle pop: a full FIFO deasserts ready even if its consumer is popping.
- Push: occurs when DEMUX_Input_Valid && DEMUX_Input_Ready.
  - The word is written to the selected FIFO at its write pointer; the write pointer toggles and count increments.
  - The unselected FIFO is untouched.
- Pop on port n: occurs when DEMUX_Output_n_Valid && DEMUX_Output_n_Ready.
  - Read pointer n toggles and count n decrements.
- Simultaneous push and pop on the same port:
  - Count is unchanged and both pointers toggle.
  - At count 1 the head word is popped and the new word becomes the head on the next cycle.
  - At count 2 this case cannot occur, because ready is low.
- Simultaneous push to one port and pop on the other: each proceeds independently.
- DEMUX_Output_n_Valid = (count n != 0).
- DEMUX_Output_n_Data = storage word at read pointer n.
  - Must hold stable while Valid is high and Ready is low.
  - When the FIFO is empty, the data output shows the stale storage word and is don't-care to consumers.
- Ordering: words keep their order within each port. There is no ordering guarantee across ports.
- Ready asserted on port n while Valid is low on port n has no effect.
- Pop on an empty FIFO never occurs: the pop condition requires Valid.
- DEMUX_Sel and DEMUX_Input_Data are ignored while DEMUX_Input_Valid is low.
- Reset, including mid-transfer:
  - All counts and pointers go to 0 and all storage words go to 0.
  - Queued words are discarded.
  - A push presented in the reset cycle is dropped.

## Timing
- Reset values, visible on the cycle after the reset edge:
  - DEMUX_Output_0_Valid = DEMUX_Output_1_Valid = 0.
  - DEMUX_Output_0_Data = DEMUX_Output_1_Data = 0.
  - DEMUX_Input_Ready = 1 for either value of DEMUX_Sel.
- Latency: a word pushed at edge k is presented on its output port from edge k+1. There is no combinational bypass from input to output.
- Throughput on one port: one word per cycle is sustained when the consumer holds Ready high, because count oscillates 0↔1 or stays at 1.
- Backpressure: with the consumer stalled, exactly 2 words are accepted; DEMUX_Input_Ready then drops for that Sel value only.
- After a pop from a full FIFO, ready for that port returns on the following cycle.

## Test plan
- Reset then idle:
  - Assert DEMUX_RESET_InHigh for 2 cycles.
  - Both Valid = 0, both Data = 0, Input_Ready = 1 for Sel = 0 and for Sel = 1.
- Routing:
  - Push 0xAAAA0000 with Sel = 0, then 0x5555FFFF with Sel = 1, with both Ready held high.
  - Port 0 shows 0xAAAA0000 one cycle after its push and port 1 shows 0x5555FFFF one cycle after its push.
  - Each word is seen for exactly one cycle; no word appears on the wrong port.
- Full/stall isolation:
  - Hold Output_0_Ready = 0 and push 0x1, 0x2, 0x3 to port 0.
  - 0x1 and 0x2 are accepted; Input_Ready = 0 while Sel = 0 and 0x3 waits; Output_0_Data stays 0x1.
  - Switching Sel to 1 gives Input_Ready = 1, and a push of 0x9 appears on port 1.
- Drain ordering:
  - From a full FIFO 0 holding 0x1, 0x2, raise Output_0_Ready.
  - 0x1 pops, then 0x2 pops on consecutive cycles; Input_Ready for Sel = 0 returns the cycle after the first pop.
- Simultaneous push/pop at count 1:
  - FIFO 1 holds 0x10; push 0x20 to port 1 while popping.
  - Count stays 1 and Output_1_Data = 0x20 on the next cycle.
- Reset mid-operation:
  - With both FIFOs full, assert reset for 1 cycle while pushing 0x77.
  - Both Valid = 0 afterward and 0x77 never appears on either port.

Source files
------------

// File: rtl/demux_1_2_buffered_if.sv
// Stream bundle for the buffered 1:2 demultiplexer: one producer-side input
// channel and two consumer-side output channels, all valid/ready.
interface demux_1_2_buffered_if #(
  parameter int INPUT_DATA_WIDTH = 32
);
  logic [INPUT_DATA_WIDTH-1:0] DEMUX_Input_Data;
  logic                        DEMUX_Input_Valid;
  logic                        DEMUX_Sel;
  logic                        DEMUX_Input_Ready;

  logic [INPUT_DATA_WIDTH-1:0] DEMUX_Output_0_Data;
  logic                        DEMUX_Output_0_Valid;
  logic                        DEMUX_Output_0_Ready;

  logic [INPUT_DATA_WIDTH-1:0] DEMUX_Output_1_Data;
  logic                        DEMUX_Output_1_Valid;
  logic                        DEMUX_Output_1_Ready;

  // Environment side: drives the input word and the consumer readies.
  modport master (
    output DEMUX_Input_Data, DEMUX_Input_Valid, DEMUX_Sel,
    input  DEMUX_Input_Ready,
    input  DEMUX_Output_0_Data, DEMUX_Output_0_Valid,
    output DEMUX_Output_0_Ready,
    input  DEMUX_Output_1_Data, DEMUX_Output_1_Valid,
    output DEMUX_Output_1_Ready
  );

  // Demux side.
  modport slave (
    input  DEMUX_Input_Data, DEMUX_Input_Valid, DEMUX_Sel,
    output DEMUX_Input_Ready,
    output DEMUX_Output_0_Data, DEMUX_Output_0_Valid,
    input  DEMUX_Output_0_Ready,
    output DEMUX_Output_1_Data, DEMUX_Output_1_Valid,
    input  DEMUX_Output_1_Ready
  );
endinterface

// File: rtl/demux_1_2_buffered.sv
// Buffered 1:2 demultiplexer. Each destination owns a 2-entry FIFO so a
// stalled consumer never blocks words already queued for the other one.
// Input ready looks only at the selected FIFO's registered count; a full
// FIFO refuses a push even when its consumer pops in the same cycle.
module demux_1_2_buffered #(
  parameter int INPUT_DATA_WIDTH = 32
) (
  input  logic                  DEMUX_CLOCK_50,
  input  logic                  DEMUX_RESET_InHigh,
  demux_1_2_buffered_if.slave   bus
);

  logic [INPUT_DATA_WIDTH-1:0] r_mem   [2][2];
  logic [1:0]                  r_wptr;
  logic [1:0]                  r_rptr;
  logic [1:0]                  r_count [2];

  logic [1:0] w_push;
  logic [1:0] w_pop;
  logic [1:0] w_out_ready;
  logic       w_in_ready;

  // Handshake decode: ready from the selected count, push/pop per port.
  always_comb begin
    w_out_ready = {bus.DEMUX_Output_1_Ready, bus.DEMUX_Output_0_Ready};
    w_in_ready  = (r_count[bus.DEMUX_Sel] != 2'd2);
    w_push[0]   = bus.DEMUX_Input_Valid & w_in_ready & ~bus.DEMUX_Sel;
    w_push[1]   = bus.DEMUX_Input_Valid & w_in_ready &  bus.DEMUX_Sel;
    w_pop[0]    = (r_count[0] != 2'd0) & w_out_ready[0];
    w_pop[1]    = (r_count[1] != 2'd0) & w_out_ready[1];
  end

  // FIFO storage, pointers and occupancy; reset wipes everything, including
  // any push presented in the reset cycle.
  always_ff @(posedge DEMUX_CLOCK_50) begin
    if (DEMUX_RESET_InHigh) begin
      r_wptr <= 2'b00;
      r_rptr <= 2'b00;
      for (int p = 0; p < 2; p++) begin
        r_count[p]  <= 2'd0;
        r_mem[p][0] <= '0;
        r_mem[p][1] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_push[p]) begin
          r_mem[p][r_wptr[p]] <= bus.DEMUX_Input_Data;
          r_wptr[p]           <= ~r_wptr[p];
        end
        if (w_pop[p]) begin
          r_rptr[p] <= ~r_rptr[p];
        end
        case ({w_push[p], w_pop[p]})
          2'b10:   r_count[p] <= r_count[p] + 2'd1;
          2'b01:   r_count[p] <= r_count[p] - 2'd1;
          default: r_count[p] <= r_count[p];
        endcase
      end
    end
  end

  assign bus.DEMUX_Input_Ready    = w_in_ready;
  assign bus.DEMUX_Output_0_Data  = r_mem[0][r_rptr[0]];
  assign bus.DEMUX_Output_0_Valid = (r_count[0] != 2'd0);
  assign bus.DEMUX_Output_1_Data  = r_mem[1][r_rptr[1]];
  assign bus.DEMUX_Output_1_Valid = (r_count[1] != 2'd0);

endmodule

// File: tb/tb_demux_1_2_buffered.sv
// Directed bench for demux_1_2_buffered. Inputs change 1 time unit after the
// rising edge and outputs are checked there, well away from the next edge.
module tb_demux_1_2_buffered;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  demux_1_2_buffered_if #(.INPUT_DATA_WIDTH(W)) bus ();

  demux_1_2_buffered #(.INPUT_DATA_WIDTH(W)) dut (
    .DEMUX_CLOCK_50     (clk),
    .DEMUX_RESET_InHigh (rst),
    .bus                (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.DEMUX_Input_Valid    = 1'b0;
    bus.DEMUX_Input_Data     = '0;
    bus.DEMUX_Sel            = 1'b0;
    bus.DEMUX_Output_0_Ready = 1'b0;
    bus.DEMUX_Output_1_Ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.DEMUX_Output_0_Valid !== 1'b0) begin errors++; $display("FAIL reset_v0 got %b want 0", bus.DEMUX_Output_0_Valid); end
    checks++; if (bus.DEMUX_Output_1_Valid !== 1'b0) begin errors++; $display("FAIL reset_v1 got %b want 0", bus.DEMUX_Output_1_Valid); end
    checks++; if (bus.DEMUX_Output_0_Data !== 32'h0) begin errors++; $display("FAIL reset_d0 got %h want 0", bus.DEMUX_Output_0_Data); end
    checks++; if (bus.DEMUX_Output_1_Data !== 32'h0) begin errors++; $display("FAIL reset_d1 got %h want 0", bus.DEMUX_Output_1_Data); end
    bus.DEMUX_Sel = 1'b0; #1;
    checks++; if (bus.DEMUX_Input_Ready !== 1'b1) begin errors++; $display("FAIL reset_rdy_sel0 got %b want 1", bus.DEMUX_Input_Ready); end
    bus.DEMUX_Sel = 1'b1; #1;
    checks++; if (bus.DEMUX_Input_Ready !== 1'b1) begin errors++; $display("FAIL reset_rdy_sel1 got %b want 1", bus.DEMUX_Input_Ready); end
    bus.DEMUX_Sel = 1'b0;
  endtask

  task automatic test_routing();
    bus.DEMUX_Output_0_Ready = 1'b1;
    bus.DEMUX_Output_1_Ready = 1'b1;
    bus.DEMUX_Input_Valid = 1'b1;
    bus.DEMUX_Sel         = 1'b0;
    bus.DEMUX_Input_Data  = 32'hAAAA0000;
    tick();
    bus.DEMUX_Sel        = 1'b1;
    bus.DEMUX_Input_Data = 32'h5555FFFF;
    checks++; if (bus.DEMUX_Output_0_Valid !== 1'b1) begin errors++; $display("FAIL route_v0 got %b want 1", bus.DEMUX_Output_0_Valid); end
    checks++; if (bus.DEMUX_Output_0_Data !== 32'hAAAA0000) begin errors++; $display("FAIL route_d0 got %h want aaaa0000", bus.DEMUX_Output_0_Data); end
    checks++; if (bus.DEMUX_Output_1_Valid !== 1'b0) begin errors++; $display("FAIL route_v1_early got %b want 0", bus.DEMUX_Output_1_Valid); end
    tick();
    bus.DEMUX_Input_Valid = 1'b0;
    checks++; if (bus.DEMUX_Output_0_Valid !== 1'b0) begin errors++; $display("FAIL route_v0_once got %b want 0", bus.DEMUX_Output_0_Valid); end
    checks++; if (bus.DEMUX_Output_1_Valid !== 1'b1) begin errors++; $display("FAIL route_v1 got %b want 1", bus.DEMUX_Output_1_Valid); end
    checks++; if (bus.DEMUX_Output_1_Data !== 32'h5555FFFF) begin errors++; $display("FAIL route_d1 got %h want 5555ffff", bus.DEMUX_Output_1_Data); end
    tick();
    checks++; if (bus.DEMUX_Output_1_Valid !== 1'b0) begin errors++; $display("FAIL route_v1_once got %b want 0", bus.DEMUX_Output_1_Valid); end
    checks++; if (bus.DEMUX_Output_0_Valid !== 1'b0) begin errors++; $display("FAIL route_v0_idle got %b want 0", bus.DEMUX_Output_0_Valid); end
  endtask

  task automatic test_full_stall();
    bus.DEMUX_Output_0_Ready = 1'b0;
    bus.DEMUX_Output_1_Ready = 1'b1;
    bus.DEMUX_Input_Valid = 1'b1;
    bus.DEMUX_Sel         = 1'b0;
    bus.DEMUX_Input_Data  = 32'h1;
    #1;
    checks++; if (bus.DEMUX_Input_Ready !== 1'b1) begin errors++; $display("FAIL full_rdy_c0 got %b want 1", bus.DEMUX_Input_Ready); end
    tick();
    bus.DEMUX_Input_Data = 32'h2;
    #1;
    checks++; if (bus.DEMUX_Input_Ready !== 1'b1) begin errors++; $display("FAIL full_rdy_c1 got %b want 1", bus.DEMUX_Input_Ready); end
    tick();
    bus.DEMUX_Input_Data = 32'h3;
    #1;
    checks++; if (bus.DEMUX_Input_Ready !== 1'b0) begin errors++; $display("FAIL full_rdy_c2 got %b want 0", bus.DEMUX_Input_Ready); end
    checks++; if (bus.DEMUX_Output_0_Data !== 32'h1) begin errors++; $display("FAIL full_head got %h want 1", bus.DEMUX_Output_0_Data); end
    tick();
    checks++; if (bus.DEMUX_Input_Ready !== 1'b0) begin errors++; $display("FAIL full_rdy_hold got %b want 0", bus.DEMUX_Input_Ready); end
    checks++; if (bus.DEMUX_Output_0_Data !== 32'h1) begin errors++; $display("FAIL full_head_hold got %h want 1", bus.DEMUX_Output_0_Data); end
    bus.DEMUX_Sel        = 1'b1;
    bus.DEMUX_Input_Data = 32'h9;
    #1;
    checks++; if (bus.DEMUX_Input_Ready !== 1'b1) begin errors++; $display("FAIL iso_rdy_sel1 got %b want 1", bus.DEMUX_Input_Ready); end
    tick();
    bus.DEMUX_Input_Valid = 1'b0;
    checks++; if (bus.DEMUX_Output_1_Valid !== 1'b1) begin errors++; $display("FAIL iso_v1 got %b want 1", bus.DEMUX_Output_1_Valid); end
    checks++; if (bus.DEMUX_Output_1_Data !== 32'h9) begin errors++; $display("FAIL iso_d1 got %h want 9", bus.DEMUX_Output_1_Data); end
    tick();
    checks++; if (bus.DEMUX_Output_1_Valid !== 1'b0) begin errors++; $display("FAIL iso_v1_pop got %b want 0", bus.DEMUX_Output_1_Valid); end
  endtask

  // Continues from test_full_stall: FIFO 0 holds 0x1, 0x2.
  task automatic test_drain();
    bus.DEMUX_Sel            = 1'b0;
    bus.DEMUX_Output_0_Ready = 1'b1;
    #1;
    checks++; if (bus.DEMUX_Input_Ready !== 1'b0) begin errors++; $display("FAIL drain_no_credit got %b want 0", bus.DEMUX_Input_Ready); end
    tick();
    checks++; if (bus.DEMUX_Output_0_Valid !== 1'b1) begin errors++; $display("FAIL drain_v0 got %b want 1", bus.DEMUX_Output_0_Valid); end
    checks++; if (bus.DEMUX_Output_0_Data !== 32'h2) begin errors++; $display("FAIL drain_d0 got %h want 2", bus.DEMUX_Output_0_Data); end
    checks++; if (bus.DEMUX_Input_Ready !== 1'b1) begin errors++; $display("FAIL drain_rdy_back got %b want 1", bus.DEMUX_Input_Ready); end
    tick();
    checks++; if (bus.DEMUX_Output_0_Valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", bus.DEMUX_Output_0_Valid); end
  endtask

  task automatic test_push_pop_count1();
    bus.DEMUX_Output_1_Ready = 1'b0;
    bus.DEMUX_Input_Valid = 1'b1;
    bus.DEMUX_Sel         = 1'b1;
    bus.DEMUX_Input_Data  = 32'h10;
    tick();
    bus.DEMUX_Input_Data     = 32'h20;
    bus.DEMUX_Output_1_Ready = 1'b1;
    checks++; if (bus.DEMUX_Output_1_Data !== 32'h10) begin errors++; $display("FAIL pp_head got %h want 10", bus.DEMUX_Output_1_Data); end
    checks++; if (bus.DEMUX_Input_Ready !== 1'b1) begin errors++; $display("FAIL pp_rdy got %b want 1", bus.DEMUX_Input_Ready); end
    tick();
    bus.DEMUX_Input_Valid    = 1'b0;
    bus.DEMUX_Output_1_Ready = 1'b0;
    checks++; if (bus.DEMUX_Output_1_Valid !== 1'b1) begin errors++; $display("FAIL pp_v1 got %b want 1", bus.DEMUX_Output_1_Valid); end
    checks++; if (bus.DEMUX_Output_1_Data !== 32'h20) begin errors++; $display("FAIL pp_d1 got %h want 20", bus.DEMUX_Output_1_Data); end
    checks++; if (bus.DEMUX_Input_Ready !== 1'b1) begin errors++; $display("FAIL pp_count1_rdy got %b want 1", bus.DEMUX_Input_Ready); end
    bus.DEMUX_Output_1_Ready = 1'b1;
    tick();
    checks++; if (bus.DEMUX_Output_1_Valid !== 1'b0) begin errors++; $display("FAIL pp_count_was1 got %b want 0", bus.DEMUX_Output_1_Valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'hC1; words[1] = 32'hC2; words[2] = 32'hC3;
    bus.DEMUX_Output_0_Ready = 1'b1;
    bus.DEMUX_Sel         = 1'b0;
    bus.DEMUX_Input_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.DEMUX_Input_Data = words[i];
      #1;
      checks++; if (bus.DEMUX_Input_Ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got %b want 1", i, bus.DEMUX_Input_Ready); end
      tick();
      checks++; if (bus.DEMUX_Output_0_Data !== words[i] || bus.DEMUX_Output_0_Valid !== 1'b1) begin
        errors++; $display("FAIL b2b_word[%0d] got %h/%b want %h/1", i, bus.DEMUX_Output_0_Data, bus.DEMUX_Output_0_Valid, words[i]);
      end
    end
    bus.DEMUX_Input_Valid = 1'b0;
    tick();
    checks++; if (bus.DEMUX_Output_0_Valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", bus.DEMUX_Output_0_Valid); end
  endtask

  task automatic test_reset_mid();
    bus.DEMUX_Output_0_Ready = 1'b0;
    bus.DEMUX_Output_1_Ready = 1'b0;
    bus.DEMUX_Input_Valid = 1'b1;
    bus.DEMUX_Sel = 1'b0; bus.DEMUX_Input_Data = 32'hA1; tick();
    bus.DEMUX_Input_Data = 32'hA2; tick();
    bus.DEMUX_Sel = 1'b1; bus.DEMUX_Input_Data = 32'hB1; tick();
    bus.DEMUX_Input_Data = 32'hB2; tick();
    bus.DEMUX_Input_Valid = 1'b0;
    bus.DEMUX_Sel = 1'b0; #1;
    checks++; if (bus.DEMUX_Input_Ready !== 1'b0) begin errors++; $display("FAIL rm_full0 got %b want 0", bus.DEMUX_Input_Ready); end
    bus.DEMUX_Sel = 1'b1; #1;
    checks++; if (bus.DEMUX_Input_Ready !== 1'b0) begin errors++; $display("FAIL rm_full1 got %b want 0", bus.DEMUX_Input_Ready); end
    rst = 1'b1;
    bus.DEMUX_Input_Valid = 1'b1;
    bus.DEMUX_Sel         = 1'b0;
    bus.DEMUX_Input_Data  = 32'h77;
    tick();
    rst = 1'b0;
    bus.DEMUX_Input_Valid = 1'b0;
    checks++; if (bus.DEMUX_Output_0_Valid !== 1'b0) begin errors++; $display("FAIL rm_v0 got %b want 0", bus.DEMUX_Output_0_Valid); end
    checks++; if (bus.DEMUX_Output_1_Valid !== 1'b0) begin errors++; $display("FAIL rm_v1 got %b want 0", bus.DEMUX_Output_1_Valid); end
    checks++; if (bus.DEMUX_Output_0_Data !== 32'h0) begin errors++; $display("FAIL rm_d0 got %h want 0", bus.DEMUX_Output_0_Data); end
    checks++; if (bus.DEMUX_Output_1_Data !== 32'h0) begin errors++; $display("FAIL rm_d1 got %h want 0", bus.DEMUX_Output_1_Data); end
    checks++; if (bus.DEMUX_Input_Ready !== 1'b1) begin errors++; $display("FAIL rm_rdy0 got %b want 1", bus.DEMUX_Input_Ready); end
    bus.DEMUX_Output_0_Ready = 1'b1;
    bus.DEMUX_Output_1_Ready = 1'b1;
    tick();
    checks++; if (bus.DEMUX_Output_0_Valid !== 1'b0 || bus.DEMUX_Output_1_Valid !== 1'b0) begin
      errors++; $display("FAIL rm_dropped got %b/%b want 0/0", bus.DEMUX_Output_0_Valid, bus.DEMUX_Output_1_Valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_routing();
    test_full_stall();
    test_drain();
    test_push_pop_count1();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
